// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM lookup path: FSM states, counter
// width and the match-vector width derivation.
package cam_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // One match bit per storage entry.
  function automatic int match_w(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder for an active-high match vector: any-hit,
// lowest matching index, and more-than-one-hit flag.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter  int ADDR_WIDTH = 2,
  localparam int MATCH_W    = match_w(ADDR_WIDTH)
) (
  input  logic [MATCH_W-1:0]    match,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  multi
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    hit   = |match;
    multi = |(match & (match - MATCH_W'(1)));
    addr  = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = MATCH_W - 1; i >= 0; i--) begin
      if (match[i]) addr = ADDR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/cam_lookup_ctrl.sv
// CAM lookup controller: issues a key to the storage array, captures the
// registered match vector and returns hit/addr/multi. Optional hit/miss
// counters are built when CAM_LOOKUP_STATS_EN is defined.
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter  int DATA_WIDTH       = 8,
  parameter  int ADDR_WIDTH       = 2,
  parameter  bit MATCH_ACTIVE_LOW = 1'b1,
  localparam int MATCH_W          = match_w(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CAM_LOOKUP_STATS_EN
  input  logic                  stats_clr,
  output logic [STATS_W-1:0]    hit_count,
  output logic [STATS_W-1:0]    miss_count,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic [DATA_WIDTH-1:0] cam_key,
  input  logic [MATCH_W-1:0]    cam_match,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_multi
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cam_key_q, cam_key_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_multi_q, rsp_multi_d;

  logic [MATCH_W-1:0]    match_norm;
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_addr;
  logic                  enc_multi;

  assign match_norm = MATCH_ACTIVE_LOW ? ~cam_match : cam_match;

  cam_prio_enc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prio_enc (
    .match (match_norm),
    .hit   (enc_hit),
    .addr  (enc_addr),
    .multi (enc_multi)
  );

  always_comb begin
    state_d     = state_q;
    cam_key_d   = cam_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_multi_d = rsp_multi_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cam_key_d = req_key;
          state_d   = ISSUE;
        end
      end
      // The array registers its match vector on this edge.
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_hit_d   = enc_hit;
        rsp_addr_d  = enc_addr;
        rsp_multi_d = enc_multi;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q     <= IDLE;
      cam_key_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cam_key_q   <= cam_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_multi_q <= rsp_multi_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign cam_key   = cam_key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_multi = rsp_multi_q;

`ifdef CAM_LOOKUP_STATS_EN
  logic [STATS_W-1:0] hit_count_q, hit_count_d;
  logic [STATS_W-1:0] miss_count_q, miss_count_d;

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (stats_clr) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else if (state_q == CAPTURE) begin
      if (enc_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + STATS_W'(1);
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Self-checking bench for cam_lookup_ctrl with a registered-read CAM storage
// model; define CAM_LOOKUP_STATS_EN to also exercise the hit/miss counters.
module tb_cam_lookup_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_key;
  logic [7:0] cam_key;
  logic [3:0] cam_match = 4'hF;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic [1:0] rsp_addr;
  logic       rsp_multi;
`ifdef CAM_LOOKUP_STATS_EN
  logic        stats_clr;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [7:0] mem [4];

  cam_lookup_ctrl #(
    .DATA_WIDTH       (8),
    .ADDR_WIDTH       (2),
    .MATCH_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CAM_LOOKUP_STATS_EN
    .stats_clr  (stats_clr),
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .cam_key    (cam_key),
    .cam_match  (cam_match),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_addr   (rsp_addr),
    .rsp_multi  (rsp_multi)
  );

  always #5 clk = ~clk;

  // Storage array: registered read, a cleared bit marks a matching entry.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) cam_match[i] <= (mem[i] == cam_key) ? 1'b0 : 1'b1;
  end

  // Reference: list the entries holding the key; report {hit, first, multi}.
  function automatic logic [3:0] ref_lookup(input logic [7:0] key);
    int cnt;
    int first;
    cnt = 0;
    first = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem[i] == key) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    return {cnt > 0, 2'(first), cnt > 1};
  endfunction

  function automatic void count_result(input logic hit, input bit clr);
    if (clr) begin
      exp_hits = 0;
      exp_misses = 0;
    end else if (hit) begin
      if (exp_hits < 65535) exp_hits++;
    end else begin
      if (exp_misses < 65535) exp_misses++;
    end
  endfunction

  // Entered and left on a falling edge with the DUT idle.
  task automatic do_lookup(input logic [7:0] key, input int stall, input bit clr_cap);
    logic [3:0] exp;
    exp = ref_lookup(key);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lookup_idle_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_key   = key;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_key   = 8'($urandom);
    n_cmp++;
    if ({req_ready, rsp_valid, cam_key} !== {1'b0, 1'b0, key}) begin
      n_bad++;
      $display("FAIL lookup_issue: ready/valid/key got %b/%b/%h want 0/0/%h",
               req_ready, rsp_valid, cam_key, key);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL lookup_capture: ready/valid got %b/%b want 0/0", req_ready, rsp_valid);
    end
`ifdef CAM_LOOKUP_STATS_EN
    stats_clr = clr_cap;
`endif
    @(posedge clk); @(negedge clk);
    count_result(exp[3], clr_cap);
`ifdef CAM_LOOKUP_STATS_EN
    stats_clr = 1'b0;
    n_cmp++;
    if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
      n_bad++;
      $display("FAIL stats_counts: hit/miss got %0d/%0d want %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
    n_cmp++;
    if ({rsp_valid, req_ready, rsp_hit, rsp_addr, rsp_multi, cam_key} !== {2'b10, exp, key}) begin
      n_bad++;
      $display("FAIL lookup_result key %h: valid/ready/hit/addr/multi got %b/%b/%b/%0d/%b want 1/0/%b/%0d/%b",
               key, rsp_valid, req_ready, rsp_hit, rsp_addr, rsp_multi, exp[3], exp[2:1], exp[0]);
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_key   = 8'($urandom);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_hit, rsp_addr, rsp_multi, cam_key} !== {2'b10, exp, key}) begin
        n_bad++;
        $display("FAIL stall_hold cycle %0d: valid/ready/hit/addr/multi/key got %b/%b/%b/%0d/%b/%h",
                 s, rsp_valid, req_ready, rsp_hit, rsp_addr, rsp_multi, cam_key);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready, cam_key} !== {1'b0, 1'b1, key}) begin
      n_bad++;
      $display("FAIL lookup_done: valid/ready/key got %b/%b/%h want 0/1/%h",
               rsp_valid, req_ready, cam_key, key);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_key   = 8'hAA;
    rsp_ready = 1'b1;
`ifdef CAM_LOOKUP_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, cam_key, rsp_hit, rsp_addr, rsp_multi} !== {1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: ready/valid/key/hit/addr/multi got %b/%b/%h/%b/%0d/%b want 1/0/00/0/0/0",
               req_ready, rsp_valid, cam_key, rsp_hit, rsp_addr, rsp_multi);
    end
`ifdef CAM_LOOKUP_STATS_EN
    n_cmp++;
    if ({hit_count, miss_count} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", hit_count, miss_count);
    end
`endif
    rst       = 1'b0;
    req_valid = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic test_directed();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h3C; mem[3] = 8'h44;
    do_lookup(8'h3C, 0, 1'b0);
    mem[0] = 8'h11; mem[1] = 8'h55; mem[2] = 8'h3C; mem[3] = 8'h55;
    do_lookup(8'h55, 0, 1'b0);
    do_lookup(8'h99, 0, 1'b0);
    mem[0] = 8'h00; mem[1] = 8'h07; mem[2] = 8'h07; mem[3] = 8'h07;
    do_lookup(8'h00, 0, 1'b0);
    do_lookup(8'h07, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hC3;
    do_lookup(8'hC3, 5, 1'b0);
    do_lookup(8'h02, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    mem[0] = 8'h5A; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    req_valid = 1'b1;
    req_key   = 8'h5A;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    n_cmp++;
    if ({rsp_valid, req_ready, cam_key} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_mid: valid/ready/key got %b/%b/%h want 0/1/00", rsp_valid, req_ready, cam_key);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_no_rsp: valid/ready got %b/%b want 0/1", rsp_valid, req_ready);
    end
    do_lookup(8'h5A, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int accepts;
    int responses;
    logic [3:0] exp;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h20; mem[3] = 8'h30;
    exp = ref_lookup(8'h20);
    accepts   = 0;
    responses = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_key   = 8'h20;
    for (int c = 0; c < 16; c++) begin
      if (req_ready === 1'b1) begin
        accepts++;
        count_result(exp[3], 1'b0);
      end
      @(posedge clk); @(negedge clk);
      if (rsp_valid === 1'b1) begin
        responses++;
        n_cmp++;
        if ({rsp_hit, rsp_addr, rsp_multi} !== exp) begin
          n_bad++;
          $display("FAIL b2b_result: hit/addr/multi got %b/%0d/%b", rsp_hit, rsp_addr, rsp_multi);
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (accepts != 4 || responses != 4) begin
      n_bad++;
      $display("FAIL b2b_throughput: accepts/responses got %0d/%0d want 4/4", accepts, responses);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain: ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] key;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 3));
      key = ($urandom_range(0, 1) == 0) ? mem[$urandom_range(0, 3)] : 8'($urandom_range(0, 5));
      do_lookup(key, $urandom_range(0, 2), 1'b0);
    end
  endtask

`ifdef CAM_LOOKUP_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    stats_clr = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    n_cmp++;
    if ({hit_count, miss_count} !== 32'd0) begin
      n_bad++;
      $display("FAIL stats_clr_idle: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    do_lookup(8'hA0, 0, 1'b0);
    do_lookup(8'hEE, 0, 1'b0);
    do_lookup(8'hA3, 1, 1'b0);
    do_lookup(8'hEF, 0, 1'b0);
    do_lookup(8'hA2, 0, 1'b0);
    n_cmp++;
    if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
      n_bad++;
      $display("FAIL stats_3h2m: got %0d/%0d want 3/2", hit_count, miss_count);
    end
    do_lookup(8'hA1, 0, 1'b1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef CAM_LOOKUP_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
